// File: rtl/seq_multi_adder.sv
// seq_multi_adder: handshaked sequential adder summing NOPS W-bit operands into an OUT_W-bit result
//   clk, rst_n        : clock, async active-low reset
//   start             : begin a transaction (IDLE only)
//   x, x_valid/x_ready: operand stream
//   busy              : transaction in progress (ACCUM or DONE)
//   s, ovf, s_valid/s_ready : result, overflow flag and result handshake
module seq_multi_adder #(
  parameter int W     = 5,
  parameter int NOPS  = 4,
  parameter int OUT_W = 6,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     x,
  input  logic             x_valid,
  output logic             x_ready,
  output logic             busy,
  output logic [OUT_W-1:0] s,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             ovf
);
  localparam int AW = W + $clog2(NOPS);
  localparam int CW = $clog2(NOPS + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t         state;
  logic [AW-1:0]  acc;
  logic [CW-1:0]  cnt;
  logic [AW-1:0]  f;
  logic           ovf_n;
  logic [OUT_W-1:0] s_n;
  assign x_ready = state == ACCUM;
  assign busy    = state != IDLE;
  assign s_valid = state == DONE;
  // f is the running sum including the operand offered this cycle; on the last
  // transfer it is the final full-precision sum
  assign f     = acc + AW'(x);
  assign ovf_n = |(f >> OUT_W);
  assign s_n   = (SAT != 0 && ovf_n) ? '1 : f[OUT_W-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      s     <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          acc   <= '0;
          cnt   <= '0;
          state <= ACCUM;
        end
        ACCUM: if (x_valid) begin
          acc <= f;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NOPS - 1)) begin
            state <= DONE;
            s     <= s_n;
            ovf   <= ovf_n;
          end
        end
        DONE: if (s_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seq_multi_adder.sv
// tb_seq_multi_adder: directed vector bench for seq_multi_adder in four configurations
module tb_seq_multi_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, x_valid = 1'b0, s_ready = 1'b0;
  logic [4:0] x = '0;
  logic start8 = 1'b0, xv8 = 1'b0, sr8 = 1'b0;
  logic [7:0] x8 = '0;
  logic xr0, b0, sv0, o0, xr1, b1, sv1, o1;
  logic xr2, b2, sv2, o2, xr3, b3, sv3, o3;
  logic [5:0] s0, s1;
  logic [10:0] s2;
  logic [9:0] s3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_multi_adder #(.SAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .start(start), .x(x), .x_valid(x_valid),
    .x_ready(xr0), .busy(b0), .s(s0), .s_valid(sv0), .s_ready(s_ready), .ovf(o0));
  seq_multi_adder #(.SAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start), .x(x), .x_valid(x_valid),
    .x_ready(xr1), .busy(b1), .s(s1), .s_valid(sv1), .s_ready(s_ready), .ovf(o1));
  seq_multi_adder #(.W(8), .NOPS(5), .OUT_W(11)) dut2 (.clk(clk), .rst_n(rst_n), .start(start8), .x(x8),
    .x_valid(xv8), .x_ready(xr2), .busy(b2), .s(s2), .s_valid(sv2), .s_ready(sr8), .ovf(o2));
  seq_multi_adder #(.W(8), .NOPS(5), .OUT_W(10)) dut3 (.clk(clk), .rst_n(rst_n), .start(start8), .x(x8),
    .x_valid(xv8), .x_ready(xr3), .busy(b3), .s(s3), .s_valid(sv3), .s_ready(sr8), .ovf(o3));

  typedef struct {
    int a, b, c, d;
    int s_wrap;
    int ovf;
    int s_sat;
  } vec_t;
  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // runs one 4-operand transaction on dut0/dut1; during stall gaps start is
  // pulsed, which ACCUM must ignore
  task automatic run5(input int a, input int b, input int c, input int d, input int gap);
    int ops[4];
    ops = '{a, b, c, d};
    start = 1'b1;
    step();
    start = 1'b0;
    check("accum_x_ready", xr0, 1);
    check("accum_busy", b0, 1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        x_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
      end
      x = 5'(ops[i]);
      x_valid = 1'b1;
      if (i == 3) check("pre_last_s_valid", sv0, 0);
      step();
      x_valid = 1'b0;
    end
    check("latency_s_valid0", sv0, 1);
    check("latency_s_valid1", sv1, 1);
    check("done_x_ready", xr0, 0);
  endtask

  task automatic accept();
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    check("accept_s_valid", sv0, 0);
    check("accept_busy", b0, 0);
  endtask

  initial begin
    vecs[0] = '{5, 31, 10, 16, 62, 0, 62};
    vecs[1] = '{23, 9, 18, 31, 17, 1, 63};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{31, 31, 31, 31, 60, 1, 63};
    vecs[4] = '{1, 2, 3, 4, 10, 0, 10};
    vecs[5] = '{31, 31, 1, 0, 63, 0, 63};
    vecs[6] = '{31, 31, 2, 0, 0, 1, 63};

    repeat (2) step();
    check("rst_s", s0, 0);
    check("rst_s_valid", sv0, 0);
    check("rst_x_ready", xr0, 0);
    check("rst_busy", b0, 0);
    check("rst_ovf", o0, 0);
    check("rst_busy8", b2, 0);
    rst_n = 1'b1;
    step();
    check("idle_x_ready", xr0, 0);

    for (int i = 0; i < 7; i++) begin
      run5(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 0);
      check($sformatf("vec%0d_s_wrap", i), s0, vecs[i].s_wrap);
      check($sformatf("vec%0d_ovf_wrap", i), o0, vecs[i].ovf);
      check($sformatf("vec%0d_s_sat", i), s1, vecs[i].s_sat);
      check($sformatf("vec%0d_ovf_sat", i), o1, vecs[i].ovf);
      accept();
      step();
    end

    run5(0, 31, 31, 31, 2);
    check("stall_s", s0, 29);
    check("stall_ovf", o0, 1);
    for (int i = 0; i < 5; i++) begin
      x = 5'd7;
      x_valid = i[0];
      start = ~i[0];
      step();
      check("hold_s", s0, 29);
      check("hold_ovf", o0, 1);
      check("hold_s_valid", sv0, 1);
      check("hold_x_ready", xr0, 0);
    end
    x_valid = 1'b0;
    start = 1'b1;
    s_ready = 1'b1;
    step();
    start = 1'b0;
    s_ready = 1'b0;
    check("start_on_accept_busy", b0, 0);
    repeat (2) step();
    check("stay_idle_busy", b0, 0);
    check("stay_idle_x_ready", xr0, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = 5'd20;
      x_valid = 1'b1;
      step();
    end
    x_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", b0, 0);
    check("async_x_ready", xr0, 0);
    check("async_s", s0, 0);
    check("async_ovf", o0, 0);
    check("async_s_valid", sv0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    run5(1, 2, 3, 4, 0);
    check("post_rst_s", s0, 10);
    check("post_rst_ovf", o0, 0);
    accept();
    step();

    for (int t = 0; t < 2; t++) begin
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
        x8 = (t == 0) ? 8'd255 : 8'(i + 1);
        xv8 = 1'b1;
        step();
      end
      xv8 = 1'b0;
      check("p_s_valid", sv2, 1);
      check("p_s11", s2, (t == 0) ? 1275 : 15);
      check("p_ovf11", o2, 0);
      check("p_s10", s3, (t == 0) ? 251 : 15);
      check("p_ovf10", o3, (t == 0) ? 1 : 0);
      sr8 = 1'b1;
      step();
      sr8 = 1'b0;
      check("p_accept_busy", b2, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
